// File: rtl/jk_updown_counter_pkg.sv
// Shared types and constants for the JK-flop based up/down counter.
package jk_updown_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/jk_updown_counter_jk_cell.sv
// Single JK flip-flop with synchronous active-low reset and complementary outputs.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic q_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   q_reg <= 1'b1;
                2'b01:   q_reg <= 1'b0;
                2'b11:   q_reg <= ~q_reg;
                default: q_reg <= q_reg;
            endcase
        end
    end

    assign q     = q_reg;
    assign q_bar = ~q_reg;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo up/down counter with start/stop control; every count bit is a JK cell
// excited from the computed next value, so load and hold share the same path.
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [WIDTH-1:0] mod_reg;
    logic [WIDTH-1:0] q_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            mod_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mod_reg   <= mod_val;
                        state_reg <= COUNT;
                    end
                end
                COUNT: begin
                    if (stop) begin
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Load wins over counting; outside COUNT the value simply holds.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_val;
        end else if (state_reg == COUNT) begin
            if (dir) begin
                q_next = (q == mod_reg) ? '0 : q + ONE;
            end else begin
                q_next = (q == '0) ? mod_reg : q - ONE;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            jk_cell u_cell (
                .clk   (clk),
                .rst   (rst),
                .j     (q_next[gi] & ~q[gi]),
                .k     (~q_next[gi] & q[gi]),
                .q     (q[gi]),
                .q_bar (q_bar[gi])
            );
        end
    endgenerate

    assign busy = (state_reg == COUNT);
    assign done = (state_reg == DONE);
    assign tc   = (state_reg == COUNT) && (dir ? (q == mod_reg) : (q == '0));

endmodule

// File: tb/tb_jk_updown_counter.sv
// Directed vector bench for jk_updown_counter at WIDTH=4.
module tb_jk_updown_counter;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       dir;
        logic       load;
        logic [3:0] load_val;
        logic [3:0] mod_val;
        logic [3:0] q;
        logic       tc;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] mod_val = 4'd0;
    logic [3:0] q;
    logic [3:0] q_bar;
    logic       tc;
    logic       busy;
    logic       done;

    int n_vec  = 0;
    int n_miss = 0;

    jk_updown_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .mod_val  (mod_val),
        .q        (q),
        .q_bar    (q_bar),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic s, input logic p, input logic d,
                                input logic l, input logic [3:0] lv, input logic [3:0] mv,
                                input logic [3:0] eq, input logic etc, input logic eb,
                                input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.dir = d; v.load = l;
        v.load_val = lv; v.mod_val = mv;
        v.q = eq; v.tc = etc; v.busy = eb; v.done = ed;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string name);
        logic [3:0] exp_qb;
        rst = v.rst; start = v.start; stop = v.stop; dir = v.dir; load = v.load;
        load_val = v.load_val; mod_val = v.mod_val;
        @(posedge clk);
        #1;
        exp_qb = ~v.q;
        n_vec++;
        if (q !== v.q || q_bar !== exp_qb || tc !== v.tc || busy !== v.busy || done !== v.done) begin
            n_miss++;
            $display("FAIL %s #%0d: got q=%h q_bar=%h tc=%b busy=%b done=%b, want q=%h q_bar=%h tc=%b busy=%b done=%b",
                     name, n_vec, q, q_bar, tc, busy, done, v.q, exp_qb, v.tc, v.busy, v.done);
        end else begin
            $display("vec %0d %s: q=%h tc=%b busy=%b done=%b ok", n_vec, name, q, tc, busy, done);
        end
    endtask

    // Idle-input step with rst released.
    task automatic step(input logic d, input logic [3:0] mv, input logic [3:0] eq,
                        input logic etc, input logic eb, input string name);
        apply(mk(1, 0, 0, d, 0, 4'd0, mv, eq, etc, eb, 0), name);
    endtask

    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0), "reset");
        apply(mk(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0), "reset");
    endtask

    vec_t tbl[$];

    initial begin
        // Table: reset, up count, stop+load, down count, load mid-count.
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 4'd5, 4'd9, 4'd0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0));
        for (int k = 1; k <= 9; k++)
            tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'(k), (k == 9), 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 4'd4, 4'd0, 4'd4, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd0, 4'd4, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd4, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 4'd2, 4'd0, 4'd2, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd5, 4'd2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd5, 4'd1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd5, 4'd0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd5, 4'd5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd5, 4'd4, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd3, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd2, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd3, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 4'd7, 4'd9, 4'd7, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd8, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd9, 1, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1, 1, 1, 4'd4, 4'd9, 4'd4, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 4'd9, 4'd4, 0, 0, 0));

        #2;
        foreach (tbl[i]) apply(tbl[i], "table");

        // Reset aborts COUNT at q==6 with no done pulse afterwards.
        do_reset();
        apply(mk(1, 1, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0), "abort_start");
        for (int k = 1; k <= 6; k++) step(1, 4'd9, 4'(k), 0, 1, "abort_cnt");
        apply(mk(0, 0, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 0, 0), "abort_rst");
        step(1, 4'd9, 4'd0, 0, 0, "abort_idle");
        step(1, 4'd9, 4'd0, 0, 0, "abort_idle");

        // mod_val changed mid-count is ignored; wrap still at 9.
        apply(mk(1, 1, 0, 1, 0, 4'd0, 4'd9, 4'd0, 0, 1, 0), "capt_start");
        for (int k = 1; k <= 8; k++) step(1, 4'd9, 4'(k), 0, 1, "capt_cnt");
        step(1, 4'd3, 4'd9, 1, 1, "capt_mod3");
        step(1, 4'd3, 4'd0, 0, 1, "capt_wrap");
        apply(mk(1, 0, 1, 1, 1, 4'd0, 4'd3, 4'd0, 0, 0, 1), "capt_stop");
        step(1, 4'd3, 4'd0, 0, 0, "capt_idle");

        // mod_reg==0: q holds 0 and tc stays high in both directions.
        apply(mk(1, 1, 0, 1, 0, 4'd0, 4'd0, 4'd0, 1, 1, 0), "mod0_start");
        step(1, 4'd7, 4'd0, 1, 1, "mod0_up");
        step(0, 4'd7, 4'd0, 1, 1, "mod0_dn");
        apply(mk(1, 0, 1, 0, 1, 4'd0, 4'd0, 4'd0, 0, 0, 1), "mod0_stop");
        step(0, 4'd0, 4'd0, 0, 0, "mod0_idle");

        // Loaded above mod_reg: climb to all-ones, wrap to 0; dir re-sampled each edge.
        apply(mk(1, 0, 0, 1, 1, 4'd13, 4'd0, 4'd13, 0, 0, 0), "ovr_load");
        apply(mk(1, 1, 0, 1, 0, 4'd0, 4'd5, 4'd13, 0, 1, 0), "ovr_start");
        step(1, 4'd5, 4'd14, 0, 1, "ovr_cnt");
        step(1, 4'd5, 4'd15, 0, 1, "ovr_cnt");
        step(1, 4'd5, 4'd0, 0, 1, "ovr_wrap");
        step(1, 4'd5, 4'd1, 0, 1, "ovr_cnt");
        step(0, 4'd5, 4'd0, 1, 1, "ovr_dirdn");
        step(0, 4'd5, 4'd5, 0, 1, "ovr_dnwrap");
        apply(mk(1, 0, 1, 0, 1, 4'd0, 4'd5, 4'd0, 0, 0, 1), "ovr_stop");
        step(0, 4'd5, 4'd0, 0, 0, "ovr_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/jk_updown_counter.md
JK_UPDOWN_COUNTER -- requirements
Module: jk_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: begin counting (IDLE only).
REQ-005 SHALL have port stop, input, 1 bit: end counting (COUNT only).
REQ-006 SHALL have port dir, input, 1 bit: 1 = up, 0 = down.
REQ-007 SHALL have port load, input, 1 bit: parallel-load request.
REQ-008 SHALL have port load_val, input, WIDTH bits: parallel-load value.
REQ-009 SHALL have port mod_val, input, WIDTH bits: terminal value, captured at start.
REQ-010 SHALL have port q, output, WIDTH bits: count value.
REQ-011 SHALL have port q_bar, output, WIDTH bits: bitwise complement of q.
REQ-012 SHALL have port tc, output, 1 bit: terminal-count decode.
REQ-013 SHALL have port busy, output, 1 bit: high in COUNT.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse in DONE.

Function
REQ-015 SHALL implement FSM states IDLE, COUNT and DONE; busy = (state==COUNT) and done = (state==DONE), both decoded from registered state.
REQ-016 In IDLE, start=1 SHALL capture mod_val into internal mod_reg and enter COUNT at the same edge; q is unchanged by start.
REQ-017 In COUNT with dir=1, each edge SHALL advance q: q==mod_reg -> 0, otherwise q+1.
REQ-018 In COUNT with dir=0, each edge SHALL advance q: q==0 -> mod_reg, otherwise q-1.
REQ-019 tc SHALL be combinational and equal (state==COUNT) && (dir ? q==mod_reg : q==0).
REQ-020 With mod_reg==0, q SHALL hold 0 in COUNT and tc SHALL stay high.
REQ-021 With q>mod_reg (after a load) counting up, q SHALL increment to all-ones, then wrap to 0.
REQ-022 load=1 in any state SHALL set q<=load_val at that edge and take priority over counting; the state transition still occurs.
REQ-023 In COUNT, stop=1 SHALL enter DONE; DONE SHALL last exactly one cycle, return to IDLE and leave q held.
REQ-024 start in COUNT/DONE and stop in IDLE/DONE SHALL be ignored; if start and stop are both high in IDLE, the block SHALL enter COUNT.
REQ-025 mod_val changes outside the start edge SHALL have no effect; dir SHALL be sampled every edge.
REQ-026 q_bar SHALL equal ~q in every cycle, including during reset.

Reset
REQ-027 rst==0 at a rising edge SHALL force q=0, q_bar=all ones, mod_reg=0 and state=IDLE, giving tc=0, busy=0 and done=0.
REQ-028 Reset SHALL override load, start and stop in the same cycle, and SHALL abort COUNT mid-sequence without a done pulse.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, COUNT, DONE) and the default width constant.
REQ-030 Each q bit SHALL be one instance of sub-module jk_cell, a JK flop with synchronous active-low reset whose output pair is (q, q_bar).
REQ-031 Each cell's excitation SHALL be derived from the computed next state n: J = n & ~q, K = ~n & q.
REQ-032 The load and hold paths SHALL also go through the same JK excitation, with no bypass register.

Verification (WIDTH=4)
REQ-033 Reset: hold rst=0 for 2 cycles -> q=0, q_bar=4'hF, tc=0, busy=0, done=0.
REQ-034 Up count: mod_val=9, dir=1, pulse start from q=0 -> q=0,1,...,9,0,1 on successive edges; tc high only while q==9; busy high throughout.
REQ-035 Down count: load_val=2, then start with mod_val=5, dir=0 -> q=2,1,0,5,4; tc high only at q==0.
REQ-036 Load mid-count: mod 9, counting up, load=1 with load_val=7 when q==3 -> q=7 next edge, then 8 while still in COUNT.
REQ-037 Stop plus load: stop=1, load=1, load_val=4 in COUNT -> q=4, done=1 for exactly one cycle, then IDLE with q held at 4.
REQ-038 Abort and capture: drive rst=0 at q==6 -> q=0, IDLE, no done pulse; in a separate run, change mod_val to 3 during COUNT at q=8 with mod 9 -> wrap still occurs at 9.
